// File: rtl/spi_frame_sequencer.sv
// Turns decoded UART command frames into 4-byte SPI transactions under one CS window,
// and returns the two MISO data bytes of read frames on a response handshake.
module spi_frame_sequencer #(
  parameter int RD_BIT = 7,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frm_valid,
  output logic             frm_ready,
  input  logic [7:0]       frm_cmd,
  input  logic [7:0]       frm_addr,
  input  logic [15:0]      frm_data,
  output logic [CNT_W-1:0] spi_tx_count,
  output logic [7:0]       spi_tx_byte,
  output logic             spi_tx_dv,
  input  logic             spi_tx_ready,
  input  logic             spi_rx_dv,
  input  logic [CNT_W-1:0] spi_rx_count,
  input  logic [7:0]       spi_rx_byte,
  output logic             rsp_valid,
  output logic [15:0]      rsp_data,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [7:0]  cmd_q;
  logic [7:0]  addr_q;
  logic [15:0] data_q;
  logic        rd_q;
  logic [7:0]  next_byte;
  logic        unused_rx_count;

  assign frm_ready       = (state == S_IDLE);
  assign busy            = (state != S_IDLE);
  assign spi_tx_count    = CNT_W'(4);
  assign unused_rx_count = ^spi_rx_count;

  // Read frames pad the data phase with zeros so only MISO carries data.
  always_comb begin
    next_byte = 8'h00;
    case (idx)
      2'd0:    next_byte = cmd_q;
      2'd1:    next_byte = addr_q;
      2'd2:    next_byte = rd_q ? 8'h00 : data_q[7:0];
      default: next_byte = rd_q ? 8'h00 : data_q[15:8];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      cmd_q       <= 8'h00;
      addr_q      <= 8'h00;
      data_q      <= 16'h0000;
      rd_q        <= 1'b0;
      spi_tx_dv   <= 1'b0;
      spi_tx_byte <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_data    <= 16'h0000;
    end else begin
      spi_tx_dv <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frm_valid) begin
            cmd_q  <= frm_cmd;
            addr_q <= frm_addr;
            data_q <= frm_data;
            rd_q   <= frm_cmd[RD_BIT];
            idx    <= 2'd0;
            state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (spi_tx_ready) begin
            spi_tx_dv   <= 1'b1;
            spi_tx_byte <= next_byte;
            state       <= S_WAIT;
          end
        end
        // Exactly one byte is outstanding here; the next one waits for its echo.
        S_WAIT: begin
          if (spi_rx_dv) begin
            if (rd_q && idx == 2'd2) rsp_data[7:0]  <= spi_rx_byte;
            if (rd_q && idx == 2'd3) rsp_data[15:8] <= spi_rx_byte;
            if (idx != 2'd3) begin
              idx   <= idx + 2'd1;
              state <= S_SEND;
            end else if (rd_q) begin
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer: plays the SPI master from the bench and
// checks MOSI bytes, strobe widths, responses, stalls, reset and back-to-back frames.
module tb_spi_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        frm_valid;
  logic        frm_ready;
  logic [7:0]  frm_cmd;
  logic [7:0]  frm_addr;
  logic [15:0] frm_data;
  logic [2:0]  spi_tx_count;
  logic [7:0]  spi_tx_byte;
  logic        spi_tx_dv;
  logic        spi_tx_ready;
  logic        spi_rx_dv;
  logic [2:0]  spi_rx_count;
  logic [7:0]  spi_rx_byte;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;

  spi_frame_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .frm_valid    (frm_valid),
    .frm_ready    (frm_ready),
    .frm_cmd      (frm_cmd),
    .frm_addr     (frm_addr),
    .frm_data     (frm_data),
    .spi_tx_count (spi_tx_count),
    .spi_tx_byte  (spi_tx_byte),
    .spi_tx_dv    (spi_tx_dv),
    .spi_tx_ready (spi_tx_ready),
    .spi_rx_dv    (spi_rx_dv),
    .spi_rx_count (spi_rx_count),
    .spi_rx_byte  (spi_rx_byte),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // A strobe lasts one full cycle, so it is seen at exactly one falling edge.
  always @(negedge clk) if (spi_tx_dv === 1'b1) strobes++;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] cmd, input logic [7:0] addr, input logic [15:0] data);
    frm_valid = valid;
    frm_cmd   = cmd;
    frm_addr  = addr;
    frm_data  = data;
  endtask

  // Serves nbytes of the current frame: waits for each strobe, checks the byte,
  // checks the strobe is one cycle wide, then echoes a MISO byte.
  task automatic serve_frame(input string tag, input logic [31:0] mosi, input logic [31:0] miso, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      int waited = 0;
      while (spi_tx_dv !== 1'b1 && waited < 50) begin
        tick();
        waited++;
      end
      checkOutput({tag, "_dv"}, {31'd0, spi_tx_dv}, 32'd1);
      checkOutput({tag, "_mosi"}, {24'd0, spi_tx_byte}, {24'd0, mosi[8*k +: 8]});
      checkOutput({tag, "_count"}, {29'd0, spi_tx_count}, 32'd4);
      tick();
      checkOutput({tag, "_dv_width"}, {31'd0, spi_tx_dv}, 32'd0);
      spi_rx_dv    = 1'b1;
      spi_rx_byte  = miso[8*k +: 8];
      spi_rx_count = 3'(k + 1);
      tick();
      spi_rx_dv = 1'b0;
    end
  endtask

  initial begin
    int s0;
    reset        = 1'b1;
    spi_tx_ready = 1'b1;
    spi_rx_dv    = 1'b0;
    spi_rx_count = 3'd0;
    spi_rx_byte  = 8'h00;
    rsp_ready    = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 16'h0000);
    tick();
    tick();
    checkOutput("rst_frm_ready", {31'd0, frm_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_tx_dv", {31'd0, spi_tx_dv}, 32'd0);
    checkOutput("rst_tx_byte", {24'd0, spi_tx_byte}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] test 1: write frame");
    applyStimulus(1'b1, 8'h02, 8'h10, 16'hBEEF);
    checkOutput("t1_frm_ready", {31'd0, frm_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 16'h0000);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    checkOutput("t1_frm_ready_low", {31'd0, frm_ready}, 32'd0);
    serve_frame("t1", 32'hBEEF1002, 32'h00000000, 4);
    checkOutput("t1_done_busy", {31'd0, busy}, 32'd0);
    checkOutput("t1_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    $display("[TB] test 2: read frame");
    applyStimulus(1'b1, 8'h81, 8'h22, 16'hFFFF);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 16'h0000);
    serve_frame("t2", 32'h00002281, 32'h1234BBAA, 4);
    checkOutput("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("t2_rsp_data", {16'd0, rsp_data}, 32'h1234);
    checkOutput("t2_busy", {31'd0, busy}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("t2_rsp_done", {31'd0, rsp_valid}, 32'd0);
    checkOutput("t2_idle", {31'd0, busy}, 32'd0);

    $display("[TB] test 3: response backpressure");
    applyStimulus(1'b1, 8'h85, 8'h33, 16'h0000);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 16'h0000);
    serve_frame("t3", 32'h00003385, 32'h5678CCDD, 4);
    applyStimulus(1'b1, 8'h03, 8'h44, 16'h1122);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("t3_hold_data", {16'd0, rsp_data}, 32'h5678);
      checkOutput("t3_hold_frm_ready", {31'd0, frm_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("t3_rsp_done", {31'd0, rsp_valid}, 32'd0);
    checkOutput("t3_frm_ready", {31'd0, frm_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 16'h0000);
    checkOutput("t3_second_accepted", {31'd0, busy}, 32'd1);
    serve_frame("t3b", 32'h11224403, 32'h00000000, 4);
    checkOutput("t3b_idle", {31'd0, busy}, 32'd0);

    $display("[TB] test 4: spurious strobe and tx stall");
    spi_rx_dv   = 1'b1;
    spi_rx_byte = 8'h99;
    tick();
    spi_rx_dv = 1'b0;
    tick();
    checkOutput("t4_spur_busy", {31'd0, busy}, 32'd0);
    checkOutput("t4_spur_data", {16'd0, rsp_data}, 32'h5678);
    checkOutput("t4_spur_dv", {31'd0, spi_tx_dv}, 32'd0);
    spi_tx_ready = 1'b0;
    applyStimulus(1'b1, 8'h04, 8'h55, 16'hA5C3);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_stall_dv", {31'd0, spi_tx_dv}, 32'd0);
      checkOutput("t4_stall_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    spi_tx_ready = 1'b1;
    serve_frame("t4", 32'hA5C35504, 32'h00000000, 4);
    checkOutput("t4_idle", {31'd0, busy}, 32'd0);

    $display("[TB] test 5: reset mid-frame");
    applyStimulus(1'b1, 8'h06, 8'h66, 16'hDEAD);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 16'h0000);
    serve_frame("t5", 32'hDEAD6606, 32'h00000000, 2);
    reset = 1'b1;
    tick();
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_frm_ready", {31'd0, frm_ready}, 32'd1);
    checkOutput("t5_dv", {31'd0, spi_tx_dv}, 32'd0);
    checkOutput("t5_rsp_data", {16'd0, rsp_data}, 32'd0);
    reset = 1'b0;
    tick();
    applyStimulus(1'b1, 8'h07, 8'h77, 16'h0102);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 16'h0000);
    serve_frame("t5b", 32'h01027707, 32'h00000000, 4);
    checkOutput("t5b_idle", {31'd0, busy}, 32'd0);

    $display("[TB] test 6: back-to-back W,R,W");
    s0 = strobes;
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 8'h08, 8'h01, 16'h3344);
    tick();
    applyStimulus(1'b1, 8'h88, 8'h02, 16'h0000);
    serve_frame("t6a", 32'h33440108, 32'h00000000, 4);
    checkOutput("t6a_ready_for_next", {31'd0, frm_ready}, 32'd1);
    tick();
    checkOutput("t6b_accepted", {31'd0, busy}, 32'd1);
    applyStimulus(1'b1, 8'h09, 8'h03, 16'h5566);
    serve_frame("t6b", 32'h00000288, 32'h9ABC0000, 4);
    checkOutput("t6b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("t6b_rsp_data", {16'd0, rsp_data}, 32'h9ABC);
    tick();
    checkOutput("t6b_rsp_done", {31'd0, rsp_valid}, 32'd0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 16'h0000);
    checkOutput("t6c_accepted", {31'd0, busy}, 32'd1);
    serve_frame("t6c", 32'h55660309, 32'h00000000, 4);
    rsp_ready = 1'b0;
    checkOutput("t6_final_idle", {31'd0, busy}, 32'd0);
    checkOutput("t6_strobes", strobes - s0, 32'd12);
    tick();
    checkOutput("t6_no_extra_frame", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
